fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end that produces the 16-bit instruction stream consumed by the core's decode/execute logic. It reads instruction words from memory over a single-outstanding request/ready interface and buffers them in a small prefetch queue. It presents one instruction per cycle to the core under a valid/accept handshake. On a taken jump it flushes the queue and restarts fetch at the jump target.

Parameters:
DEPTH, 4, prefetch queue entries; power of two, at least 2.
RESET_VECTOR, 16'h0000, first word address fetched after reset.

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
MemRequest  output  1  read request; held high until MemReady
MemAddress  output  16  word address of the outstanding read; stable while MemRequest=1
MemReady  input  1  one-cycle pulse; MemData valid; completes the outstanding request
MemData  input  16  instruction word returned by memory
Instruction  output  16  head-of-queue instruction; 16'h0000 when queue empty
InstructionAddress  output  16  word address of Instruction; 16'h0000 when empty
InstructionValid  output  1  queue non-empty
InstructionAccept  input  1  core consumes head this cycle; ignored when InstructionValid=0
Redirect  input  1  taken jump: flush and refetch
RedirectTarget  input  16  new fetch word address, sampled when Redirect=1

Behaviour:
- Reset (Reset=1 at the clock edge) is synchronous and active-high; it applies mid-transaction as well. Resulting state: MemRequest=0, MemAddress=RESET_VECTOR, FetchPC=RESET_VECTOR, queue empty (InstructionValid=0, Instruction=0, InstructionAddress=0), state IDLE. An outstanding memory request is abandoned, and the memory side must tolerate this.
- FetchPC: internal 16-bit next-fetch word address. It increments by 1 per accepted response and wraps 16'hFFFF -> 16'h0000.
- FSM states: IDLE, WAIT, DISCARD. MemRequest=1 exactly in WAIT and DISCARD.
- IDLE:
  - If Redirect: FetchPC<=RedirectTarget, stay IDLE.
  - Else if count<DEPTH: go to WAIT with MemAddress<=FetchPC.
- WAIT, MemReady=0:
  - If Redirect: flush queue, FetchPC<=RedirectTarget, go to DISCARD.
  - Else hold.
- WAIT, MemReady=1:
  - If Redirect: drop MemData, flush, FetchPC<=RedirectTarget, go to IDLE.
  - Else push {MemAddress, MemData} and set FetchPC<=MemAddress+1.
  - If post-push count<DEPTH, stay in WAIT with MemAddress<=MemAddress+1 (back-to-back requests).
  - Otherwise go to IDLE.
- DISCARD: hold the request until MemReady, then drop the data and go to IDLE. A Redirect arriving in DISCARD only updates FetchPC.
- Request issue never overfills the queue: a request is issued only when count<DEPTH, and only one request is outstanding at a time.
- Queue:
  - Output is the head entry, combinational from storage registers.
  - Pop when InstructionValid & InstructionAccept & !Redirect.
  - Simultaneous push and pop leaves count unchanged.
  - A pop while full frees a slot; the next request issues from IDLE on the following cycle.
- Redirect has priority over push and pop in the same cycle. The queue is empty on the cycle after a Redirect.
- Latency:
  - Memory returning MemReady in the same cycle as the request: first instruction valid 2 cycles after Reset deasserts.
  - Steady state: 1 instruction per cycle with zero-wait memory.

Decomposition:
- Package micropop_pkg:
  - typedef word_t (logic[15:0]).
  - enum fetch_state_t {IDLE, WAIT, DISCARD}.
  - struct fetch_entry_t {word_t Address; word_t Data}.
  - Default RESET_VECTOR constant.
- Sub-module fetch_queue: DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, empty and full. The FSM and address logic stay in fetch_unit.

Test Plan:
- Reset release, memory returns MemReady with MemData=addr+16'h1000 in the same cycle as the request -> MemAddress 0,1,2,3 on consecutive cycles; Instruction 16'h1000 at InstructionAddress 0 valid 2 cycles after Reset; one instruction per cycle thereafter with InstructionAccept=1.
- InstructionAccept=0 held -> exactly DEPTH=4 requests issued, then MemRequest=0; queue holds addresses 0..3. Assert one accept -> exactly one new request at address 4.
- Redirect to 16'h0040 while WAIT and memory stalled 3 cycles -> DISCARD entered; the late MemData is never presented; next request has MemAddress=16'h0040; queue empty the cycle after Redirect.
- Redirect coinciding with MemReady and InstructionAccept -> data dropped, no pop counted, queue empty, next request at RedirectTarget.
- Redirect to 16'hFFFE, zero-wait memory -> addresses FFFE, FFFF, 0000, 0001 delivered in order with matching InstructionAddress.
- Reset asserted while in WAIT with 2 entries queued -> next cycle MemRequest=0, InstructionValid=0, MemAddress=RESET_VECTOR; fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/micropop_pkg.sv
// Shared types for the instruction fetch front end.
package micropop_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t Address;
    word_t Data;
  } fetch_entry_t;

  localparam word_t DEFAULT_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {address, instruction} entries; flush empties it in one cycle.
module fetch_queue
  import micropop_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_entry,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   storage [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        storage[wr_ptr] <= push_entry;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding memory reads into a prefetch queue.
// IDLE    | no request outstanding
// WAIT    | request outstanding, response will be queued
// DISCARD | request outstanding after a redirect, response will be dropped
module fetch_unit
  import micropop_pkg::*;
#(
  parameter int    DEPTH        = 4,
  parameter word_t RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic  Clock,
  input  logic  Reset,
  output logic  MemRequest,
  output word_t MemAddress,
  input  logic  MemReady,
  input  word_t MemData,
  output word_t Instruction,
  output word_t InstructionAddress,
  output logic  InstructionValid,
  input  logic  InstructionAccept,
  input  logic  Redirect,
  input  word_t RedirectTarget
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state;
  fetch_state_t  state_next;
  word_t         fetch_pc;
  word_t         pc_next;
  word_t         addr_next;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_push;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign pop              = !empty && InstructionAccept && !Redirect;
  assign count_after_push = count + CW'(1) - CW'(pop);
  assign push_entry       = '{Address: MemAddress, Data: MemData};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (Clock),
    .reset      (Reset),
    .push       (push),
    .pop        (pop),
    .flush      (Redirect),
    .push_entry (push_entry),
    .head       (head),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      MemAddress <= RESET_VECTOR;
      fetch_pc   <= RESET_VECTOR;
    end else begin
      state      <= state_next;
      MemAddress <= addr_next;
      fetch_pc   <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = MemAddress;
    pc_next    = fetch_pc;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (Redirect) begin
          pc_next = RedirectTarget;
        end else if (!full) begin
          state_next = WAIT;
          addr_next  = fetch_pc;
        end
      end
      WAIT: begin
        if (MemReady) begin
          if (Redirect) begin
            pc_next    = RedirectTarget;
            state_next = IDLE;
          end else begin
            push    = 1'b1;
            pc_next = MemAddress + 16'd1;
            // Keep streaming while the queue still has room after this push.
            if (count_after_push < CW'(DEPTH)) begin
              addr_next = MemAddress + 16'd1;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (Redirect) begin
          pc_next    = RedirectTarget;
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (Redirect) begin
          pc_next = RedirectTarget;
        end
        if (MemReady) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign MemRequest         = (state != IDLE);
  assign InstructionValid   = !empty;
  assign Instruction        = empty ? 16'h0000 : head.Data;
  assign InstructionAddress = empty ? 16'h0000 : head.Address;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns MemAddress+16'h1000 as data.
module tb_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic        MemRequest;
  logic [15:0] MemAddress;
  logic        MemReady;
  logic [15:0] MemData;
  logic [15:0] Instruction;
  logic [15:0] InstructionAddress;
  logic        InstructionValid;
  logic        InstructionAccept;
  logic        Redirect;
  logic [15:0] RedirectTarget;

  logic mem_auto;
  logic mem_ready_man;
  int   n_assert;
  int   n_fail;
  int   req_count;
  logic [15:0] exp_addr;

  assign MemReady = mem_auto ? MemRequest : mem_ready_man;
  assign MemData  = MemAddress + 16'h1000;

  fetch_unit dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .MemRequest         (MemRequest),
    .MemAddress         (MemAddress),
    .MemReady           (MemReady),
    .MemData            (MemData),
    .Instruction        (Instruction),
    .InstructionAddress (InstructionAddress),
    .InstructionValid   (InstructionValid),
    .InstructionAccept  (InstructionAccept),
    .Redirect           (Redirect),
    .RedirectTarget     (RedirectTarget)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset             = 1'b1;
    InstructionAccept = 1'b0;
    Redirect          = 1'b0;
    RedirectTarget    = 16'h0000;
    mem_auto          = 1'b1;
    mem_ready_man     = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Reset             = 1'b1;
    InstructionAccept = 1'b0;
    Redirect          = 1'b0;
    RedirectTarget    = 16'h0000;
    mem_auto          = 1'b1;
    mem_ready_man     = 1'b0;
    step();
    step();

    // Reset state
    check("rst_req",   16'(MemRequest), 16'd0);
    check("rst_valid", 16'(InstructionValid), 16'd0);
    check("rst_instr", Instruction, 16'h0000);
    check("rst_iaddr", InstructionAddress, 16'h0000);
    check("rst_maddr", MemAddress, 16'h0000);

    // Zero-wait streaming with accept held high
    Reset = 1'b0;
    InstructionAccept = 1'b1;
    check("s_idle_req", 16'(MemRequest), 16'd0);
    step();
    check("s_req0",   16'(MemRequest), 16'd1);
    check("s_maddr0", MemAddress, 16'h0000);
    check("s_valid0", 16'(InstructionValid), 16'd0);
    step();
    check("s_valid1", 16'(InstructionValid), 16'd1);
    check("s_instr0", Instruction, 16'h1000);
    check("s_iaddr0", InstructionAddress, 16'h0000);
    check("s_maddr1", MemAddress, 16'h0001);
    for (int i = 1; i < 4; i++) begin
      step();
      check("s_instr", Instruction, 16'h1000 + 16'(i));
      check("s_iaddr", InstructionAddress, 16'(i));
      check("s_maddr", MemAddress, 16'(i + 1));
    end

    // Accept held low: exactly DEPTH requests, then one more per accept
    do_reset();
    req_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (MemRequest) req_count++;
      step();
    end
    check("fill_reqs",  16'(req_count), 16'd4);
    check("fill_req",   16'(MemRequest), 16'd0);
    check("fill_valid", 16'(InstructionValid), 16'd1);
    check("fill_instr", Instruction, 16'h1000);
    check("fill_iaddr", InstructionAddress, 16'h0000);
    InstructionAccept = 1'b1;
    step();
    InstructionAccept = 1'b0;
    check("pop1_instr", Instruction, 16'h1001);
    check("pop1_req",   16'(MemRequest), 16'd0);
    step();
    check("refill_req",   16'(MemRequest), 16'd1);
    check("refill_maddr", MemAddress, 16'h0004);
    req_count = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (MemRequest) req_count++;
    end
    check("refill_extra", 16'(req_count), 16'd0);
    InstructionAccept = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_instr", Instruction, 16'h1000 + 16'(i));
      check("drain_iaddr", InstructionAddress, 16'(i));
      step();
    end

    // Redirect while memory stalls: DISCARD drops the late response
    do_reset();
    mem_auto = 1'b0;
    step();
    check("d_req",   16'(MemRequest), 16'd1);
    check("d_maddr", MemAddress, 16'h0000);
    Redirect       = 1'b1;
    RedirectTarget = 16'h0040;
    step();
    Redirect = 1'b0;
    check("d_valid_after_redir", 16'(InstructionValid), 16'd0);
    check("d_req_held",          16'(MemRequest), 16'd1);
    check("d_maddr_held",        MemAddress, 16'h0000);
    step();
    check("d_req_held2", 16'(MemRequest), 16'd1);
    mem_ready_man = 1'b1;
    step();
    mem_ready_man = 1'b0;
    check("d_req_done",   16'(MemRequest), 16'd0);
    check("d_valid_done", 16'(InstructionValid), 16'd0);
    mem_auto = 1'b1;
    step();
    check("d_new_req",   16'(MemRequest), 16'd1);
    check("d_new_maddr", MemAddress, 16'h0040);
    step();
    check("d_instr", Instruction, 16'h1040);
    check("d_iaddr", InstructionAddress, 16'h0040);

    // Redirect coinciding with MemReady and accept
    Redirect          = 1'b1;
    RedirectTarget    = 16'h0080;
    InstructionAccept = 1'b1;
    step();
    Redirect          = 1'b0;
    InstructionAccept = 1'b0;
    check("c_valid", 16'(InstructionValid), 16'd0);
    check("c_instr", Instruction, 16'h0000);
    check("c_req",   16'(MemRequest), 16'd0);
    step();
    check("c_req2",  16'(MemRequest), 16'd1);
    check("c_maddr", MemAddress, 16'h0080);
    step();
    check("c_instr2", Instruction, 16'h1080);
    check("c_iaddr2", InstructionAddress, 16'h0080);

    // Redirect near the top of the address space: fetch wraps to 0
    Redirect          = 1'b1;
    RedirectTarget    = 16'hFFFE;
    InstructionAccept = 1'b1;
    step();
    Redirect = 1'b0;
    check("w_valid", 16'(InstructionValid), 16'd0);
    step();
    check("w_maddr", MemAddress, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      step();
      exp_addr = 16'hFFFE + 16'(i);
      check("w_iaddr", InstructionAddress, exp_addr);
      check("w_instr", Instruction, exp_addr + 16'h1000);
    end

    // Reset mid-transaction with two entries queued
    do_reset();
    step();
    step();
    step();
    mem_auto = 1'b0;
    check("r_pre_valid", 16'(InstructionValid), 16'd1);
    check("r_pre_req",   16'(MemRequest), 16'd1);
    check("r_pre_maddr", MemAddress, 16'h0002);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("r_req",   16'(MemRequest), 16'd0);
    check("r_valid", 16'(InstructionValid), 16'd0);
    check("r_instr", Instruction, 16'h0000);
    check("r_maddr", MemAddress, 16'h0000);
    mem_auto = 1'b1;
    step();
    check("r_new_req",   16'(MemRequest), 16'd1);
    check("r_new_maddr", MemAddress, 16'h0000);
    step();
    check("r_instr2", Instruction, 16'h1000);
    check("r_iaddr2", InstructionAddress, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
